// File: rtl/sr_encoder_pkg.sv
// ============================================================================
// sr_encoder_pkg -- shared types, RV32I field constants and helpers | rev 1.0
// ============================================================================
`default_nettype none

package sr_encoder_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_OR   = 4'd1,
    OP_SRL  = 4'd2,
    OP_SLTU = 4'd3,
    OP_SUB  = 4'd4,
    OP_ADDI = 4'd5,
    OP_LUI  = 4'd6,
    OP_BEQ  = 4'd7,
    OP_BNE  = 4'd8,
    OP_LI   = 4'd9,
    OP_NOP  = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SECOND = 2'd1,
    ST_FULL   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_U = 2'd2,
    FMT_B = 2'd3
  } fmt_e;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE   = 2'd0;
  localparam err_code_t ERR_IMM    = 2'd1;
  localparam err_code_t ERR_BRANCH = 2'd2;
  localparam err_code_t ERR_OP     = 2'd3;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // upper = imm[31:11]; a value fits a signed 12-bit field iff these bits agree
  function automatic logic fits_s12(input logic [20:0] upper);
    return (upper == '0) || (upper == '1);
  endfunction

  // (imm + 0x800) >> 12, computed from imm[31:11] only
  function automatic logic [19:0] li_hi(input logic [20:0] upper);
    return upper[20:1] + {19'b0, upper[0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sr_encoder_if.sv
// ============================================================================
// sr_encoder_if -- request handshake and instruction-memory write bus | rev 1.0
// ============================================================================
`default_nettype none

interface sr_encoder_if #(
  parameter int ADDR_W = 6
) ();
  import sr_encoder_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;
  err_code_t         err_code;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready, wr_en, wr_addr, wr_data, count, full, err, err_code
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready, wr_en, wr_addr, wr_data, count, full, err, err_code
  );

endinterface

`default_nettype wire

// File: rtl/sr_instr_pack.sv
// ============================================================================
// sr_instr_pack -- combinational RV32I field packer (R/I/U/B) | rev 1.0
// ============================================================================
`default_nettype none

module sr_instr_pack
  import sr_encoder_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [6:0]  opcode,
  input  logic [6:0]  funct7,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word
);

  // U-format expects the upper value already placed in imm[31:12]
  always_comb begin
    word = '0;
    case (fmt)
      FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_U:   word = {imm[31:12], rd, opcode};
      FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      default: word = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sr_encoder.sv
// ============================================================================
// sr_encoder -- request-to-RV32I encoder writing an instruction memory | rev 1.0
// ============================================================================
`default_nettype none

module sr_encoder
  import sr_encoder_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  sr_encoder_if.slave bus
);

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_inc;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              err;
  err_code_t         err_code;
  logic [4:0]        pend_rd;
  logic [11:0]       pend_lo;

  logic              full;
  logic              in_ready;
  logic              accept;

  fmt_e              fmt;
  logic [6:0]        opcode;
  logic [6:0]        funct7;
  logic [2:0]        funct3;
  logic [4:0]        p_rd;
  logic [4:0]        p_rs1;
  logic [4:0]        p_rs2;
  logic [31:0]       p_imm;
  logic [31:0]       packed_word;
  err_code_t         req_err;
  logic              two_words;
  logic [19:0]       li_upper;
  logic              br_ok;

  assign count_inc = count + ONE;
  assign full      = (count == CAP);
  assign in_ready  = (state == ST_RUN) && !full;
  // restart wins over a same-cycle request
  assign accept    = bus.in_valid && in_ready && !restart;

  assign li_upper  = li_hi(bus.in_imm[31:11]);
  assign br_ok     = ((bus.in_imm[31:12] == '0) || (bus.in_imm[31:12] == '1)) && !bus.in_imm[0];

  always_comb begin
    fmt       = FMT_R;
    opcode    = OPC_OP;
    funct7    = F7_BASE;
    funct3    = F3_ADD_SUB;
    p_rd      = bus.in_rd;
    p_rs1     = bus.in_rs1;
    p_rs2     = bus.in_rs2;
    p_imm     = bus.in_imm;
    req_err   = ERR_NONE;
    two_words = 1'b0;

    if (state == ST_SECOND) begin
      // trailing ADDI rd,rd,lo of a two-word LI
      fmt    = FMT_I;
      opcode = OPC_OP_IMM;
      p_rd   = pend_rd;
      p_rs1  = pend_rd;
      p_imm  = {{20{pend_lo[11]}}, pend_lo};
    end else begin
      case (bus.in_op)
        OP_ADD:  ;
        OP_OR:   funct3 = F3_OR;
        OP_SRL:  funct3 = F3_SRL;
        OP_SLTU: funct3 = F3_SLTU;
        OP_SUB:  funct7 = F7_SUB;
        OP_ADDI: begin
          fmt    = FMT_I;
          opcode = OPC_OP_IMM;
          if (!fits_s12(bus.in_imm[31:11])) req_err = ERR_IMM;
        end
        OP_LUI: begin
          fmt    = FMT_U;
          opcode = OPC_LUI;
          p_imm  = {bus.in_imm[19:0], 12'b0};
        end
        OP_BEQ, OP_BNE: begin
          fmt    = FMT_B;
          opcode = OPC_BRANCH;
          funct3 = (bus.in_op == OP_BNE) ? F3_BNE : F3_BEQ;
          if (!br_ok) req_err = ERR_BRANCH;
        end
        OP_LI: begin
          if (li_upper == '0) begin
            fmt    = FMT_I;
            opcode = OPC_OP_IMM;
            p_rs1  = '0;
            p_imm  = {{20{bus.in_imm[11]}}, bus.in_imm[11:0]};
          end else begin
            fmt    = FMT_U;
            opcode = OPC_LUI;
            p_imm  = {li_upper, 12'b0};
            if (bus.in_imm[11:0] != '0) begin
              two_words = 1'b1;
              // a split LI is never started without room for both words
              if (count_inc == CAP) req_err = ERR_IMM;
            end
          end
        end
        OP_NOP: begin
          fmt    = FMT_I;
          opcode = OPC_OP_IMM;
          p_rd   = '0;
          p_rs1  = '0;
          p_imm  = '0;
        end
        default: req_err = ERR_OP;
      endcase
    end
  end

  sr_instr_pack u_pack (
    .fmt    (fmt),
    .opcode (opcode),
    .funct7 (funct7),
    .funct3 (funct3),
    .rd     (p_rd),
    .rs1    (p_rs1),
    .rs2    (p_rs2),
    .imm    (p_imm),
    .word   (packed_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      count    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      pend_rd  <= '0;
      pend_lo  <= '0;
    end else if (restart) begin
      state    <= ST_RUN;
      count    <= '0;
      wr_en    <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_RUN: begin
          if (accept) begin
            if (req_err != ERR_NONE) begin
              if (!err) begin
                err      <= 1'b1;
                err_code <= req_err;
              end
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= count[ADDR_W-1:0];
              wr_data <= packed_word;
              count   <= count_inc;
              if (two_words) begin
                state   <= ST_SECOND;
                pend_rd <= bus.in_rd;
                pend_lo <= bus.in_imm[11:0];
              end else if (count_inc == CAP) begin
                state <= ST_FULL;
              end
            end
          end
        end
        ST_SECOND: begin
          wr_en   <= 1'b1;
          wr_addr <= count[ADDR_W-1:0];
          wr_data <= packed_word;
          count   <= count_inc;
          state   <= (count_inc == CAP) ? ST_FULL : ST_RUN;
        end
        ST_FULL: ;
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_addr;
  assign bus.wr_data  = wr_data;
  assign bus.count    = count;
  assign bus.full     = full;
  assign bus.err      = err;
  assign bus.err_code = err_code;

endmodule

`default_nettype wire

// File: tb/tb_sr_encoder.sv
// ============================================================================
// tb_sr_encoder -- directed scoreboard bench for sr_encoder (ADDR_W 6 and 2) | rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sr_encoder;
  import sr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        restart;
  logic        sel;
  logic        valid;
  logic [3:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  always #5 clk = ~clk;

  sr_encoder_if #(.ADDR_W(6)) bus_l ();
  sr_encoder_if #(.ADDR_W(2)) bus_s ();

  assign bus_l.in_valid = valid & ~sel;
  assign bus_l.in_op    = op;
  assign bus_l.in_rd    = rd;
  assign bus_l.in_rs1   = rs1;
  assign bus_l.in_rs2   = rs2;
  assign bus_l.in_imm   = imm;
  assign bus_s.in_valid = valid & sel;
  assign bus_s.in_op    = op;
  assign bus_s.in_rd    = rd;
  assign bus_s.in_rs1   = rs1;
  assign bus_s.in_rs2   = rs2;
  assign bus_s.in_imm   = imm;

  sr_encoder #(.ADDR_W(6)) dut_l (.clk(clk), .rst_n(rst_n), .restart(restart), .bus(bus_l.slave));
  sr_encoder #(.ADDR_W(2)) dut_s (.clk(clk), .rst_n(rst_n), .restart(restart), .bus(bus_s.slave));

  logic        ready_o, wr_en_o, full_o, err_o;
  logic [5:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic [6:0]  count_o;
  logic [1:0]  code_o;

  assign ready_o   = sel ? bus_s.in_ready : bus_l.in_ready;
  assign wr_en_o   = sel ? bus_s.wr_en    : bus_l.wr_en;
  assign wr_addr_o = sel ? {4'b0, bus_s.wr_addr} : bus_l.wr_addr;
  assign wr_data_o = sel ? bus_s.wr_data  : bus_l.wr_data;
  assign count_o   = sel ? {4'b0, bus_s.count} : bus_l.count;
  assign full_o    = sel ? bus_s.full     : bus_l.full;
  assign err_o     = sel ? bus_s.err      : bus_l.err;
  assign code_o    = sel ? bus_s.err_code : bus_l.err_code;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] data;
  } step_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [5:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // advance one clock, then score any write that edge produced
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (wr_en_o === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: got addr %h data %h expected no write", wr_addr_o, wr_data_o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", {26'b0, wr_addr_o}, {26'b0, e.addr});
        chk("wr_data", wr_data_o, e.data);
      end
    end
  endtask

  task automatic req(input logic [3:0] o, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic [31:0] im);
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  step_t tbl [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{OP_OR,   5'd4,  5'd5,  5'd6,  32'd0,        32'h0062E233};
    tbl[1]  = '{OP_SRL,  5'd7,  5'd8,  5'd9,  32'd0,        32'h009453B3};
    tbl[2]  = '{OP_SLTU, 5'd10, 5'd11, 5'd12, 32'd0,        32'h00C5B533};
    tbl[3]  = '{OP_SUB,  5'd3,  5'd1,  5'd2,  32'd0,        32'h402081B3};
    tbl[4]  = '{OP_ADDI, 5'd1,  5'd2,  5'd0,  32'hFFFFF800, 32'h80010093};
    tbl[5]  = '{OP_ADDI, 5'd1,  5'd0,  5'd0,  32'd2047,     32'h7FF00093};
    tbl[6]  = '{OP_LUI,  5'd2,  5'd0,  5'd0,  32'h000ABCDE, 32'hABCDE137};
    tbl[7]  = '{OP_NOP,  5'd31, 5'd31, 5'd31, 32'h0000DEAD, 32'h00000013};
    tbl[8]  = '{OP_BEQ,  5'd0,  5'd1,  5'd2,  32'hFFFFFFF8, 32'hFE208CE3};
    tbl[9]  = '{OP_BNE,  5'd0,  5'd3,  5'd4,  32'd4094,     32'h7E419FE3};
    tbl[10] = '{OP_BEQ,  5'd0,  5'd0,  5'd0,  32'hFFFFF000, 32'h80000063};
    tbl[11] = '{OP_LI,   5'd6,  5'd9,  5'd0,  32'd5,        32'h00500313};
    tbl[12] = '{OP_LI,   5'd7,  5'd9,  5'd0,  32'h00003000, 32'h000033B7};
    tbl[13] = '{OP_LI,   5'd8,  5'd9,  5'd0,  32'hFFFFFFFF, 32'hFFF00413};

    sel = 1'b0; rst_n = 1'b0; restart = 1'b0; valid = 1'b0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;

    repeat (3) tick();
    chk("rst_wr_en",   {31'b0, wr_en_o}, 32'd0);
    chk("rst_wr_addr", {26'b0, wr_addr_o}, 32'd0);
    chk("rst_wr_data", wr_data_o, 32'd0);
    chk("rst_count",   {25'b0, count_o}, 32'd0);
    chk("rst_full",    {31'b0, full_o}, 32'd0);
    chk("rst_err",     {31'b0, err_o}, 32'd0);
    chk("rst_code",    {30'b0, code_o}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", {31'b0, ready_o}, 32'd1);

    // ADD x3,x1,x2 must appear one edge after acceptance
    push(6'd0, 32'h002081B3);
    req(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("add_latency", exp_q.size(), 32'd0);
    chk("add_count", {25'b0, count_o}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      push(6'(i + 1), tbl[i].data);
      req(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
      chk($sformatf("tbl%0d_drain", i), exp_q.size(), 32'd0);
    end
    chk("tbl_count", {25'b0, count_o}, 32'd15);

    // two-word LI
    push(6'd15, 32'h123462B7);
    push(6'd16, 32'hFFF28293);
    op = OP_LI; rd = 5'd5; rs1 = 5'd0; rs2 = 5'd0; imm = 32'h12345FFF;
    valid = 1'b1;
    tick();
    chk("li_ready_low", {31'b0, ready_o}, 32'd0);
    valid = 1'b0;
    tick();
    chk("li_ready_back", {31'b0, ready_o}, 32'd1);
    chk("li_drain", exp_q.size(), 32'd0);
    chk("li_count", {25'b0, count_o}, 32'd17);

    // error capture: first cause sticks
    req(OP_BNE, 5'd0, 5'd1, 5'd2, 32'd3);
    chk("bne_odd_err",  {31'b0, err_o}, 32'd1);
    chk("bne_odd_code", {30'b0, code_o}, 32'd2);
    chk("bne_odd_count", {25'b0, count_o}, 32'd17);
    req(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048);
    chk("sticky_code_2", {30'b0, code_o}, 32'd2);

    restart = 1'b1; tick(); restart = 1'b0;
    chk("restart_err",   {31'b0, err_o}, 32'd0);
    chk("restart_code",  {30'b0, code_o}, 32'd0);
    chk("restart_count", {25'b0, count_o}, 32'd0);

    req(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048);
    chk("addi_range_code", {30'b0, code_o}, 32'd1);
    req(4'd12, 5'd1, 5'd0, 5'd0, 32'd0);
    chk("illegal_keeps_code", {30'b0, code_o}, 32'd1);
    chk("illegal_err", {31'b0, err_o}, 32'd1);
    chk("err_no_writes", {25'b0, count_o}, 32'd0);

    restart = 1'b1; tick(); restart = 1'b0;
    req(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd4096);
    chk("beq_range_code", {30'b0, code_o}, 32'd2);

    // restart dominates a same-cycle request
    restart = 1'b1;
    op = OP_ADD; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; imm = '0;
    valid = 1'b1;
    tick();
    valid = 1'b0; restart = 1'b0;
    chk("restart_prio_count", {25'b0, count_o}, 32'd0);
    chk("restart_prio_err", {31'b0, err_o}, 32'd0);

    // restart while the ADDI half of an LI is pending
    push(6'd0, 32'h123462B7);
    req(OP_LI, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    restart = 1'b1; tick(); restart = 1'b0;
    tick();
    chk("restart_second_count", {25'b0, count_o}, 32'd0);
    chk("restart_second_drain", exp_q.size(), 32'd0);
    chk("restart_second_ready", {31'b0, ready_o}, 32'd1);

    // reset while the ADDI half of an LI is pending
    push(6'd0, 32'h123462B7);
    req(OP_LI, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    tick();
    chk("rst_second_count", {25'b0, count_o}, 32'd0);
    chk("rst_second_drain", exp_q.size(), 32'd0);

    // ADDR_W=2 instance: fill to capacity with back-to-back NOPs
    sel = 1'b1;
    for (int i = 0; i < 4; i++) push(6'(i), 32'h00000013);
    op = OP_NOP; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = '0;
    valid = 1'b1;
    repeat (5) tick();
    valid = 1'b0;
    chk("small_full",  {31'b0, full_o}, 32'd1);
    chk("small_ready", {31'b0, ready_o}, 32'd0);
    chk("small_count", {25'b0, count_o}, 32'd4);
    chk("small_drain", exp_q.size(), 32'd0);
    tick();
    chk("small_no_wrap", {25'b0, count_o}, 32'd4);

    restart = 1'b1; tick(); restart = 1'b0;
    chk("small_restart_count", {25'b0, count_o}, 32'd0);
    chk("small_restart_ready", {31'b0, ready_o}, 32'd1);
    chk("small_restart_full",  {31'b0, full_o}, 32'd0);

    // split LI with only one free slot is rejected
    for (int i = 0; i < 3; i++) begin
      push(6'(i), 32'h00000013);
      req(OP_NOP, 5'd0, 5'd0, 5'd0, 32'd0);
    end
    req(OP_LI, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    chk("small_li_err",   {31'b0, err_o}, 32'd1);
    chk("small_li_code",  {30'b0, code_o}, 32'd1);
    chk("small_li_count", {25'b0, count_o}, 32'd3);
    tick();
    chk("final_drain", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
